// File: rtl/hvh_pkg.sv
// Shared types and helpers for the multi-channel HV hold timer.
package hvh_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hvh_state_e;

  localparam int unsigned TICK_1S_100MHZ = 100000000;

  function automatic int unsigned presc_width(input int unsigned ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/hvh_channel.sv
// One HV hold channel: launch edge detect, IDLE/HOLD FSM, tick prescaler and remain counter.
module hvh_channel
  import hvh_pkg::*;
#(
  parameter int DELAY_W     = 8,
  parameter int TICK_CYCLES = TICK_1S_100MHZ,
  parameter int RETRIG      = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               launch_i,
  input  logic               abort_i,
  input  logic               inhibit_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               out_o,
  output logic               done_o,
  output logic [DELAY_W-1:0] remain_o,
  output logic               hold_d_o
);

  localparam int unsigned    PW      = presc_width(TICK_CYCLES);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_CYCLES - 1);

  hvh_state_e         state_q, state_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [DELAY_W-1:0] rem_q, rem_d;
  logic               done_q, done_d;
  logic               launch_q, armed_q;
  logic               edge_w, kill_w;

  // armed_q masks the first cycle after reset so a launch held through release cannot fire.
  assign edge_w = launch_i & ~launch_q & armed_q;
  assign kill_w = abort_i | inhibit_i;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_w && !kill_w) begin
          if (delay_i != '0) begin
            state_d = HOLD;
            pre_d   = '0;
            rem_d   = delay_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (kill_w) begin
          state_d = IDLE;
          pre_d   = '0;
          rem_d   = '0;
        end else if (edge_w && (RETRIG != 0)) begin
          pre_d = '0;
          if (delay_i == '0) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = delay_i;
          end
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (rem_q == DELAY_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - DELAY_W'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      launch_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      launch_q <= launch_i;
      armed_q  <= 1'b1;
    end
  end

  assign out_o    = (state_q == HOLD);
  assign done_o   = done_q;
  assign remain_o = rem_q;
  assign hold_d_o = (state_d == HOLD);

endmodule

// File: rtl/hv_hold_timer_mc.sv
// Multi-channel HV hold timer: slices the buses to CHANNELS independent hold channels and forms busy.
module hv_hold_timer_mc
  import hvh_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DELAY_W     = 8,
  parameter int TICK_CYCLES = TICK_1S_100MHZ,
  parameter int RETRIG      = 0
) (
  input  logic                        clk_hvh,
  input  logic                        rst_hvh,
  input  logic [CHANNELS-1:0]         hvh_launch,
  input  logic [CHANNELS-1:0]         hvh_abort,
  input  logic                        hvh_inhibit,
  input  logic [CHANNELS*DELAY_W-1:0] hvh_delay,
  output logic [CHANNELS-1:0]         hvh_out,
  output logic [CHANNELS-1:0]         hvh_done,
  output logic                        hvh_busy,
  output logic [CHANNELS*DELAY_W-1:0] hvh_remain
);

  logic [CHANNELS-1:0] hold_d;
  logic                busy_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    hvh_channel #(
      .DELAY_W    (DELAY_W),
      .TICK_CYCLES(TICK_CYCLES),
      .RETRIG     (RETRIG)
    ) u_ch (
      .clk_i    (clk_hvh),
      .rst_i    (rst_hvh),
      .launch_i (hvh_launch[i]),
      .abort_i  (hvh_abort[i]),
      .inhibit_i(hvh_inhibit),
      .delay_i  (hvh_delay[i*DELAY_W +: DELAY_W]),
      .out_o    (hvh_out[i]),
      .done_o   (hvh_done[i]),
      .remain_o (hvh_remain[i*DELAY_W +: DELAY_W]),
      .hold_d_o (hold_d[i])
    );
  end

  // Registered from next-state so busy lines up with hvh_out exactly.
  always_ff @(posedge clk_hvh or posedge rst_hvh) begin
    if (rst_hvh) busy_q <= 1'b0;
    else         busy_q <= |hold_d;
  end

  assign hvh_busy = busy_q;

endmodule

// File: tb/tb_hv_hold_timer_mc.sv
// Directed bench for hv_hold_timer_mc: one RETRIG=0 and one RETRIG=1 instance, TICK_CYCLES=10.
module tb_hv_hold_timer_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  la = '0, ab = '0, lb = '0, abb = '0;
  logic        inh = 1'b0, inhb = 1'b0;
  logic [15:0] dly = '0, dlyb = '0;
  logic [1:0]  out_a, done_a, out_b, done_b;
  logic        busy_a, busy_b;
  logic [15:0] rem_a, rem_b;

  int n_cmp = 0;
  int n_err = 0;
  int hi, hi1, dn, dn1, bad;

  always #5 clk = ~clk;

  hv_hold_timer_mc #(.CHANNELS(2), .DELAY_W(8), .TICK_CYCLES(10), .RETRIG(0)) u_dut (
    .clk_hvh(clk), .rst_hvh(rst), .hvh_launch(la), .hvh_abort(ab), .hvh_inhibit(inh),
    .hvh_delay(dly), .hvh_out(out_a), .hvh_done(done_a), .hvh_busy(busy_a), .hvh_remain(rem_a)
  );

  hv_hold_timer_mc #(.CHANNELS(2), .DELAY_W(8), .TICK_CYCLES(10), .RETRIG(1)) u_dut_rt (
    .clk_hvh(clk), .rst_hvh(rst), .hvh_launch(lb), .hvh_abort(abb), .hvh_inhibit(inhb),
    .hvh_delay(dlyb), .hvh_out(out_b), .hvh_done(done_b), .hvh_busy(busy_b), .hvh_remain(rem_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with launch0 held high through release
    la  = 2'b01;
    dly = 16'h0303;
    repeat (3) tick();
    chk("rst_out",    32'(out_a),  32'd0);
    chk("rst_done",   32'(done_a), 32'd0);
    chk("rst_busy",   32'(busy_a), 32'd0);
    chk("rst_remain", 32'(rem_a),  32'd0);
    chk("rst_out_b",  32'(out_b),  32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("held_launch_out",  32'(out_a),  32'd0);
    chk("held_launch_busy", 32'(busy_a), 32'd0);
    la = '0;
    repeat (2) tick();

    // Basic hold, delay 3 -> 30 cycles high, one done
    dly[7:0] = 8'd3;
    la[0] = 1'b1; tick(); la[0] = 1'b0;
    hi = 0; dn = 0;
    for (int t = 0; t < 40; t++) begin
      if (out_a[0])  hi++;
      if (done_a[0]) dn++;
      if (t == 0)  chk("basic_rem_t0",  32'(rem_a[7:0]), 32'd3);
      if (t == 10) chk("basic_rem_t10", 32'(rem_a[7:0]), 32'd2);
      if (t == 29) chk("basic_rem_t29", 32'(rem_a[7:0]), 32'd1);
      if (t == 30) begin
        chk("basic_done_t30", 32'(done_a[0]),  32'd1);
        chk("basic_rem_t30",  32'(rem_a[7:0]), 32'd0);
      end
      tick();
    end
    chk("basic_high_cycles", 32'(hi), 32'd30);
    chk("basic_done_count",  32'(dn), 32'd1);

    // Delay zero: done once, no hold
    dly[7:0] = 8'd0;
    la[0] = 1'b1; tick(); la[0] = 1'b0;
    hi = 0; dn = 0;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) chk("dz_done_t0", 32'(done_a[0]), 32'd1);
      if (out_a[0])  hi++;
      if (done_a[0]) dn++;
      tick();
    end
    chk("dz_high",  32'(hi), 32'd0);
    chk("dz_done",  32'(dn), 32'd1);

    // Abort 12 cycles into a delay-5 hold
    dly[7:0] = 8'd5;
    la[0] = 1'b1; tick(); la[0] = 1'b0;
    hi = 0; dn = 0;
    for (int t = 0; t < 30; t++) begin
      if (out_a[0])  hi++;
      if (done_a[0]) dn++;
      if (t == 13) chk("abort_rem", 32'(rem_a[7:0]), 32'd0);
      if (t == 12) ab[0] = 1'b1;
      if (t == 14) ab[0] = 1'b0;
      tick();
    end
    chk("abort_high", 32'(hi), 32'd13);
    chk("abort_done", 32'(dn), 32'd0);

    // Inhibit while both channels hold; launch during inhibit discarded
    dly = 16'h0505;
    la = 2'b11; tick(); la = 2'b00;
    repeat (4) tick();
    chk("inh_pre_out",  32'(out_a),  32'd3);
    chk("inh_pre_busy", 32'(busy_a), 32'd1);
    inh = 1'b1; tick();
    chk("inh_out",  32'(out_a),  32'd0);
    chk("inh_busy", 32'(busy_a), 32'd0);
    chk("inh_rem",  32'(rem_a),  32'd0);
    la = 2'b11; tick(); la = 2'b00; tick();
    inh = 1'b0;
    dn = 0; hi = 0;
    for (int t = 0; t < 5; t++) begin
      if (out_a != 2'b00)  hi++;
      if (done_a != 2'b00) dn++;
      tick();
    end
    chk("inh_discard_out",  32'(hi), 32'd0);
    chk("inh_discard_done", 32'(dn), 32'd0);

    // Second edge 15 cycles into a delay-2 hold: RETRIG=1 extends, RETRIG=0 ignores
    dly[7:0] = 8'd2; dlyb[7:0] = 8'd2;
    la[0] = 1'b1; lb[0] = 1'b1; tick(); la[0] = 1'b0; lb[0] = 1'b0;
    hi = 0; dn = 0; hi1 = 0; dn1 = 0;
    for (int t = 0; t < 50; t++) begin
      if (out_a[0])  hi++;
      if (done_a[0]) dn++;
      if (out_b[0])  hi1++;
      if (done_b[0]) dn1++;
      if (t == 15) chk("rt_reload_rem", 32'(rem_b[7:0]), 32'd2);
      if (t == 14) begin la[0] = 1'b1; lb[0] = 1'b1; end
      if (t == 15) begin la[0] = 1'b0; lb[0] = 1'b0; end
      tick();
    end
    chk("rt1_high", 32'(hi1), 32'd35);
    chk("rt1_done", 32'(dn1), 32'd1);
    chk("rt0_high", 32'(hi),  32'd20);
    chk("rt0_done", 32'(dn),  32'd1);

    // Independence: ch0 delay 255, ch1 delay 1 launched together
    dly = {8'd1, 8'd255};
    la = 2'b11; tick(); la = 2'b00;
    hi = 0; hi1 = 0; bad = 0;
    for (int t = 0; t < 2560; t++) begin
      if (out_a[0]) hi++;
      if (out_a[1]) hi1++;
      if (busy_a !== (t < 2550)) bad++;
      if (t == 0) chk("ind_rem0", 32'(rem_a[7:0]), 32'd255);
      if (t == 10) begin
        chk("ind_done1", 32'(done_a[1]), 32'd1);
        chk("ind_out0",  32'(out_a[0]),  32'd1);
      end
      tick();
    end
    chk("ind_high0",  32'(hi),  32'd2550);
    chk("ind_high1",  32'(hi1), 32'd10);
    chk("ind_busy_bad", 32'(bad), 32'd0);

    // Asynchronous reset mid-hold
    dly[7:0] = 8'd3;
    la[0] = 1'b1; tick(); la[0] = 1'b0;
    repeat (5) tick();
    chk("mid_pre_out", 32'(out_a[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_out",  32'(out_a),  32'd0);
    chk("mid_async_busy", 32'(busy_a), 32'd0);
    tick();
    rst = 1'b0;
    hi = 0; dn = 0;
    for (int t = 0; t < 40; t++) begin
      if (out_a != 2'b00)  hi++;
      if (done_a != 2'b00) dn++;
      tick();
    end
    chk("mid_after_out",  32'(hi), 32'd0);
    chk("mid_after_done", 32'(dn), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
